cci_mpf_rd_req_arbiter: RTL and testbench

- Round-robin arbiter that shares one MPF read-request channel (c0) between N_CLIENTS AFU-side requesters. It sits between the client engines and the AFU edge of the MPF pipeline.
- Tags each request with the client ID in the top mdata bits and routes read responses back to the issuing client.
- Enforces a per-client outstanding-read limit, so one client cannot consume all MAX_ACTIVE_REQS slots.

---
 rtl/cci_mpf_rd_arb_pkg.sv | 28 ++
 rtl/cci_mpf_rr_arb.sv | 48 ++++
 rtl/cci_mpf_rd_req_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_cci_mpf_rd_req_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cci_mpf_rd_arb_pkg.sv
// Shared types and sizing helpers for the MPF c0 read-request arbiter.
package cci_mpf_rd_arb_pkg;

  localparam int unsigned MAX_CLIENTS = 16;

  // Widest client ID the arbiter supports (16 clients).
  typedef logic [$clog2(MAX_CLIENTS)-1:0] t_client_id;

  // Widest per-client outstanding counter (one client owning all 128 slots).
  typedef logic [7:0] t_outstanding_cnt;

  // Client ID width; never less than one bit.
  function automatic int unsigned calc_id_w(input int unsigned n_clients);
    return (n_clients < 2) ? 1 : $clog2(n_clients);
  endfunction

  // Per-client share of the total outstanding-read budget.
  function automatic int unsigned calc_client_limit(input int unsigned max_reqs,
                                                    input int unsigned n_clients);
    return max_reqs / n_clients;
  endfunction

  // Counter width able to hold 0..limit inclusive.
  function automatic int unsigned calc_cnt_w(input int unsigned limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/cci_mpf_rr_arb.sv
// N-way round-robin picker. Grant is combinational; the rotating priority
// pointer is held here and advances past each granted requester.
module cci_mpf_rr_arb
  import cci_mpf_rd_arb_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = calc_id_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any,
  output logic [IDX_W-1:0] rr_ptr
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic [IDX_W-1:0] cand;

  // Scan from the pointer upward; N is a power of two so the index wraps naturally.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = rr_ptr_q + IDX_W'(k);
      if (en && !grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
    rr_ptr_d = grant_any ? IDX_W'(grant_idx + 1'b1) : rr_ptr_q;
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;

endmodule

// File: rtl/cci_mpf_rd_req_arbiter.sv
// Round-robin arbiter sharing the MPF c0 read-request channel between
// N_CLIENTS requesters, with per-client outstanding limits and response routing.
// Optional: CCI_MPF_RD_ARB_STATS_EN adds per-client saturating grant counters.
module cci_mpf_rd_req_arbiter
  import cci_mpf_rd_arb_pkg::*;
#(
  parameter  int unsigned N_CLIENTS       = 4,
  parameter  int unsigned ADDR_WIDTH      = 42,
  parameter  int unsigned MDATA_WIDTH     = 16,
  parameter  int unsigned MAX_ACTIVE_REQS = 128,
  localparam int unsigned ID_W            = calc_id_w(N_CLIENTS),
  localparam int unsigned CL_MDATA_W      = MDATA_WIDTH - ID_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_CLIENTS-1:0]            cl_req_valid,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0] cl_req_addr,
  input  logic [N_CLIENTS*CL_MDATA_W-1:0] cl_req_mdata,
  output logic [N_CLIENTS-1:0]            cl_req_grant,
  output logic                            c0_req_valid,
  output logic [ADDR_WIDTH-1:0]           c0_req_addr,
  output logic [MDATA_WIDTH-1:0]          c0_req_mdata,
  input  logic                            c0_almost_full,
  input  logic                            c0_rsp_valid,
  input  logic [MDATA_WIDTH-1:0]          c0_rsp_mdata,
  input  logic                            c0_rsp_eop,
  output logic [N_CLIENTS-1:0]            cl_rsp_valid,
  output logic [CL_MDATA_W-1:0]           cl_rsp_mdata,
  output logic                            cl_rsp_eop,
  output logic                            err_underflow,
  input  logic [ID_W-1:0]                 stat_sel,
  output logic [31:0]                     stat_grants
);

  localparam int unsigned CLIENT_LIMIT = calc_client_limit(MAX_ACTIVE_REQS, N_CLIENTS);
  localparam int unsigned CNT_W        = calc_cnt_w(CLIENT_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(CLIENT_LIMIT);

  logic [N_CLIENTS-1:0] elig;
  logic [N_CLIENTS-1:0] grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_any;
  logic [ID_W-1:0]      rr_ptr;

  logic [CNT_W-1:0] cnt_q [N_CLIENTS];
  logic [CNT_W-1:0] cnt_d [N_CLIENTS];
  logic             err_q, err_d;

  logic                   req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q,  req_addr_d;
  logic [MDATA_WIDTH-1:0] req_mdata_q, req_mdata_d;
  logic [CL_MDATA_W-1:0]  req_cl_mdata;

  logic [ID_W-1:0]        rsp_id;
  logic [N_CLIENTS-1:0]   rsp_valid_q, rsp_valid_d;
  logic [CL_MDATA_W-1:0]  rsp_mdata_q, rsp_mdata_d;
  logic                   rsp_eop_q,   rsp_eop_d;

  // A client competes only while valid and below its outstanding share.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++)
      elig[i] = cl_req_valid[i] && (cnt_q[i] < LIMIT_CNT);
  end

  cci_mpf_rr_arb #(.N(N_CLIENTS)) u_rr_arb (
    .clk       (clk),
    .rst       (reset),
    .req       (elig),
    .en        (!c0_almost_full && !reset),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any),
    .rr_ptr    (rr_ptr)
  );

  assign cl_req_grant = grant;

  // Capture the granted client's request and tag it with the client ID.
  always_comb begin
    req_valid_d  = grant_any;
    req_addr_d   = '0;
    req_cl_mdata = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (grant[i]) begin
        req_addr_d   = cl_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        req_cl_mdata = cl_req_mdata[i*CL_MDATA_W +: CL_MDATA_W];
      end
    end
    req_mdata_d = {grant_idx, req_cl_mdata};
  end

  // Route responses to the client named in the top mdata bits.
  always_comb begin
    rsp_id      = c0_rsp_mdata[MDATA_WIDTH-1 -: ID_W];
    rsp_valid_d = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++)
      rsp_valid_d[i] = c0_rsp_valid && (rsp_id == ID_W'(i));
    rsp_mdata_d = c0_rsp_mdata[CL_MDATA_W-1:0];
    rsp_eop_d   = c0_rsp_eop;
  end

  // Outstanding counters: grant increments, EOP decrements, both cancel out.
  always_comb begin
    logic dec;
    dec   = 1'b0;
    err_d = err_q;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      cnt_d[i] = cnt_q[i];
      dec      = c0_rsp_valid && c0_rsp_eop && (rsp_id == ID_W'(i));
      if (grant[i] && !dec) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec && !grant[i]) begin
        if (cnt_q[i] == '0) err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // Request, response and counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_mdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_mdata_q <= '0;
      rsp_eop_q   <= 1'b0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < N_CLIENTS; i++) cnt_q[i] <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_mdata_q <= req_mdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_mdata_q <= rsp_mdata_d;
      rsp_eop_q   <= rsp_eop_d;
      err_q       <= err_d;
      for (int unsigned i = 0; i < N_CLIENTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign c0_req_valid  = req_valid_q;
  assign c0_req_addr   = req_addr_q;
  assign c0_req_mdata  = req_mdata_q;
  assign cl_rsp_valid  = rsp_valid_q;
  assign cl_rsp_mdata  = rsp_mdata_q;
  assign cl_rsp_eop    = rsp_eop_q;
  assign err_underflow = err_q;

  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;

`ifdef CCI_MPF_RD_ARB_STATS_EN
  logic [31:0] grant_cnt_q [N_CLIENTS];
  logic [31:0] grant_cnt_d [N_CLIENTS];
  logic [31:0] stat_q, stat_d;

  // Saturating per-client grant counts and the selected-client readout.
  always_comb begin
    for (int unsigned i = 0; i < N_CLIENTS; i++)
      grant_cnt_d[i] = (grant[i] && (grant_cnt_q[i] != '1)) ? grant_cnt_q[i] + 32'd1
                                                            : grant_cnt_q[i];
    stat_d = grant_cnt_q[stat_sel];
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q <= '0;
      for (int unsigned i = 0; i < N_CLIENTS; i++) grant_cnt_q[i] <= '0;
    end else begin
      stat_q <= stat_d;
      for (int unsigned i = 0; i < N_CLIENTS; i++) grant_cnt_q[i] <= grant_cnt_d[i];
    end
  end

  assign stat_grants = stat_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_grants     = '0;
`endif

endmodule

// File: tb/tb_cci_mpf_rd_req_arbiter.sv
// Scoreboard bench for cci_mpf_rd_req_arbiter: a per-cycle reference model
// predicts grants and pushes the next-cycle outputs; a monitor pops and compares.
module tb_cci_mpf_rd_req_arbiter;

  localparam int N = 4, AW = 42, MW = 16, MAXR = 128, IDW = 2, CLW = 14, LIMIT = MAXR / N;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      cl_req_valid;
  logic [N*AW-1:0]   cl_req_addr;
  logic [N*CLW-1:0]  cl_req_mdata;
  logic [N-1:0]      cl_req_grant;
  logic              c0_req_valid;
  logic [AW-1:0]     c0_req_addr;
  logic [MW-1:0]     c0_req_mdata;
  logic              c0_almost_full;
  logic              c0_rsp_valid;
  logic [MW-1:0]     c0_rsp_mdata;
  logic              c0_rsp_eop;
  logic [N-1:0]      cl_rsp_valid;
  logic [CLW-1:0]    cl_rsp_mdata;
  logic              cl_rsp_eop;
  logic              err_underflow;
  logic [IDW-1:0]    stat_sel;
  logic [31:0]       stat_grants;

  cci_mpf_rd_req_arbiter #(
    .N_CLIENTS(N), .ADDR_WIDTH(AW), .MDATA_WIDTH(MW), .MAX_ACTIVE_REQS(MAXR)
  ) dut (
    .clk(clk), .reset(reset),
    .cl_req_valid(cl_req_valid), .cl_req_addr(cl_req_addr), .cl_req_mdata(cl_req_mdata),
    .cl_req_grant(cl_req_grant),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c0_almost_full(c0_almost_full),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_eop(c0_rsp_eop),
    .cl_rsp_valid(cl_rsp_valid), .cl_rsp_mdata(cl_rsp_mdata), .cl_rsp_eop(cl_rsp_eop),
    .err_underflow(err_underflow), .stat_sel(stat_sel), .stat_grants(stat_grants)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rv;
    logic [AW-1:0] ra;
    logic [MW-1:0] rm;
    logic [N-1:0]  sv;
    logic [CLW-1:0] sm;
    logic          se;
    logic [31:0]   st;
  } exp_t;

  exp_t q[$];
  exp_t idle_e = '{rv: 1'b0, ra: '0, rm: '0, sv: '0, sm: '0, se: 1'b0, st: '0};

  int      m_ptr;
  int      m_cnt [N];
  bit      m_err;
  longint  m_stat [N];
  int      n_checks = 0;
  int      n_fail   = 0;
  bit      done     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i]  = 0;
      m_stat[i] = 0;
    end
  endtask

  // First client at or after the pointer that is valid and under its share.
  function automatic int model_pick();
    if (c0_almost_full) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (cl_req_valid[c] && m_cnt[c] < LIMIT) return c;
    end
    return -1;
  endfunction

  // Reference model: check this cycle's grant, predict next cycle's outputs.
  initial begin
    model_reset();
    q.push_back(idle_e);
    forever begin
      @(posedge clk); #7;
      if (reset) begin
        check("grant_in_reset", 64'(cl_req_grant), 64'd0);
        model_reset();
        q.delete();
        q.push_back(idle_e);
      end else begin
        int   g;
        int   id;
        exp_t e;
        g = model_pick();
        check("grant", 64'(cl_req_grant), (g >= 0) ? (64'd1 << g) : 64'd0);
        check("err_underflow", 64'(err_underflow), 64'(m_err));
        e = idle_e;
        if (g >= 0) begin
          e.rv = 1'b1;
          e.ra = cl_req_addr[g*AW +: AW];
          e.rm = {IDW'(g), cl_req_mdata[g*CLW +: CLW]};
        end
        id = int'(c0_rsp_mdata[MW-1 -: IDW]);
        if (c0_rsp_valid) begin
          e.sv = N'(1) << id;
          e.sm = c0_rsp_mdata[CLW-1:0];
          e.se = c0_rsp_eop;
        end
`ifdef CCI_MPF_RD_ARB_STATS_EN
        e.st = 32'(m_stat[stat_sel]);
`endif
        q.push_back(e);
        if (g >= 0) begin
          m_cnt[g]++;
          m_ptr = (g + 1) % N;
          if (m_stat[g] < 64'hFFFF_FFFF) m_stat[g]++;
        end
        if (c0_rsp_valid && c0_rsp_eop) begin
          if (m_cnt[id] > 0) m_cnt[id]--;
          else               m_err = 1'b1;
        end
      end
    end
  end

  // Monitor: compare registered outputs against the scoreboard each cycle.
  initial begin
    forever begin
      @(posedge clk); #6;
      if (q.size() == 0) begin
        check("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (reset) begin
          e = idle_e;
          check("err_in_reset", 64'(err_underflow), 64'd0);
        end
        check("c0_req_valid", 64'(c0_req_valid), 64'(e.rv));
        if (e.rv) begin
          check("c0_req_addr", 64'(c0_req_addr), 64'(e.ra));
          check("c0_req_mdata", 64'(c0_req_mdata), 64'(e.rm));
        end
        check("cl_rsp_valid", 64'(cl_rsp_valid), 64'(e.sv));
        if (e.sv != '0) begin
          check("cl_rsp_mdata", 64'(cl_rsp_mdata), 64'(e.sm));
          check("cl_rsp_eop", 64'(cl_rsp_eop), 64'(e.se));
        end
        check("stat_grants", 64'(stat_grants), 64'(e.st));
      end
    end
  end

  task automatic drive(input logic [N-1:0] v, input bit af, input bit rv,
                       input logic [MW-1:0] rm, input bit eop);
    @(posedge clk); #1;
    cl_req_valid   = v;
    c0_almost_full = af;
    c0_rsp_valid   = rv;
    c0_rsp_mdata   = rm;
    c0_rsp_eop     = eop;
    for (int i = 0; i < N; i++) begin
      cl_req_addr[i*AW +: AW]    = AW'({$urandom(), $urandom()});
      cl_req_mdata[i*CLW +: CLW] = CLW'($urandom());
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (cycles) drive('0, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cl_req_valid = '0; cl_req_addr = '0; cl_req_mdata = '0;
    c0_almost_full = 1'b0; c0_rsp_valid = 1'b0; c0_rsp_mdata = '0; c0_rsp_eop = 1'b0;
    stat_sel = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // All clients continuously valid: grants rotate 0,1,2,3.
    repeat (12) drive('1, 1'b0, 1'b0, '0, 1'b0);

    // Client 2 alone hits its 32-request share; one EOP frees exactly one slot.
    do_reset(2);
    repeat (36) drive(4'b0100, 1'b0, 1'b0, '0, 1'b0);
    drive(4'b0100, 1'b0, 1'b1, 16'h8005, 1'b1);
    repeat (4) drive(4'b0100, 1'b0, 1'b0, '0, 1'b0);

    // almost_full stalls granting; rotation resumes from the saved pointer.
    do_reset(2);
    repeat (3) drive('1, 1'b0, 1'b0, '0, 1'b0);
    repeat (5) drive('1, 1'b1, 1'b0, '0, 1'b0);
    repeat (6) drive('1, 1'b0, 1'b0, '0, 1'b0);

    // Same-cycle grant and EOP for client 1 at count 3, then underflow on client 3.
    do_reset(2);
    repeat (3) drive(4'b0010, 1'b0, 1'b0, '0, 1'b0);
    drive(4'b0010, 1'b0, 1'b1, {2'd1, 14'h0123}, 1'b1);
    drive('0, 1'b0, 1'b1, {2'd3, 14'h0042}, 1'b1);
    repeat (4) drive('0, 1'b0, 1'b0, '0, 1'b0);

    // Randomized traffic with an asynchronous reset pulse part-way through.
    do_reset(2);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      int id;
      bit rv;
      id = $urandom_range(0, N - 1);
      rv = ($urandom_range(0, 99) < 40) && (m_cnt[id] > 0 || $urandom_range(0, 29) == 0);
      stat_sel = IDW'($urandom());
      drive(N'($urandom()), ($urandom_range(0, 99) < 20), rv,
            {IDW'(id), CLW'($urandom())}, ($urandom_range(0, 3) != 0));
      if (cyc == 700) begin
        #2 reset = 1'b1;
        repeat (2) drive('1, 1'b0, 1'b0, '0, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
      end
    end

    // Ten grants to client 0, then read its grant statistic.
    do_reset(2);
    stat_sel = '0;
    repeat (10) drive(4'b0001, 1'b0, 1'b0, '0, 1'b0);
    repeat (4) drive('0, 1'b0, 1'b0, '0, 1'b0);
`ifdef CCI_MPF_RD_ARB_STATS_EN
    #5 check("stat_grants_client0", 64'(stat_grants), 64'd10);
`else
    #5 check("stat_grants_tied", 64'(stat_grants), 64'd0);
`endif

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: got running, expected finished");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

endmodule
